// File: rtl/ovl_unchange_sched_if.sv
// rtl/ovl_unchange_sched_if.sv - request/grant/report bundle for the shared unchange-window scheduler
interface ovl_unchange_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
);
  logic                       enable_i;
  logic [NUM_REQ-1:0]         req_i;
  logic [NUM_REQ*WIDTH-1:0]   test_expr_i;
  logic [NUM_REQ-1:0]         gnt_o;
  logic                       busy_o;
  logic                       fire_o;
  logic [ID_W-1:0]            fire_id_o;
  logic                       done_o;
  logic [ID_W-1:0]            done_id_o;

  modport master (
    output enable_i, req_i, test_expr_i,
    input  gnt_o, busy_o, fire_o, fire_id_o, done_o, done_id_o
  );

  modport slave (
    input  enable_i, req_i, test_expr_i,
    output gnt_o, busy_o, fire_o, fire_id_o, done_o, done_id_o
  );
endinterface

// File: rtl/ovl_unchange_sched.sv
// rtl/ovl_unchange_sched.sv - round-robin scheduler sharing one value-unchanged window checker
// Grants one requester, snapshots its slice, reports done or fire tagged with the requester id.
module ovl_unchange_sched #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 4,
  parameter int NUM_CKS = 2
) (
  input  logic               clock,
  input  logic               reset,
  ovl_unchange_sched_if.slave bus
);
  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(NUM_CKS + 1);

  typedef enum logic {IDLE, WINDOW} state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               busy_q, busy_d;
  logic               fire_q, fire_d;
  logic [ID_W-1:0]    fire_id_q, fire_id_d;
  logic               done_q, done_d;
  logic [ID_W-1:0]    done_id_q, done_id_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   snap_q, snap_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [ID_W-1:0]    gid_q, gid_d;

  logic               found;
  logic [ID_W-1:0]    win;
  logic [WIDTH-1:0]   win_slice;
  logic [WIDTH-1:0]   cur_slice;

  // Search starts just past the last winner so every held request is served in turn.
  always_comb begin
    int idx;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(ptr_q) + k) % NUM_REQ;
      if (!found && bus.req_i[idx]) begin
        found = 1'b1;
        win   = ID_W'(idx);
      end
    end
  end

  assign win_slice = bus.test_expr_i[int'(win)*WIDTH +: WIDTH];
  assign cur_slice = bus.test_expr_i[int'(gid_q)*WIDTH +: WIDTH];

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    busy_d    = busy_q;
    fire_d    = 1'b0;
    fire_id_d = fire_id_q;
    done_d    = 1'b0;
    done_id_d = done_id_q;
    cnt_d     = cnt_q;
    snap_d    = snap_q;
    ptr_d     = ptr_q;
    gid_d     = gid_q;
    unique case (state_q)
      IDLE: begin
        if (bus.enable_i && found) begin
          state_d = WINDOW;
          gnt_d   = {{(NUM_REQ-1){1'b0}}, 1'b1} << win;
          busy_d  = 1'b1;
          ptr_d   = win;
          gid_d   = win;
          snap_d  = win_slice;
          cnt_d   = CNT_W'(NUM_CKS);
        end
      end
      WINDOW: begin
        if (!bus.enable_i || !bus.req_i[gid_q]) begin
          state_d = IDLE;
          gnt_d   = '0;
          busy_d  = 1'b0;
        end else if (cur_slice != snap_q) begin
          state_d   = IDLE;
          gnt_d     = '0;
          busy_d    = 1'b0;
          fire_d    = 1'b1;
          fire_id_d = gid_q;
        end else if (cnt_q == CNT_W'(1)) begin
          state_d   = IDLE;
          gnt_d     = '0;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          done_id_d = gid_q;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      busy_q    <= 1'b0;
      fire_q    <= 1'b0;
      fire_id_q <= '0;
      done_q    <= 1'b0;
      done_id_q <= '0;
      cnt_q     <= '0;
      snap_q    <= '0;
      ptr_q     <= ID_W'(NUM_REQ - 1);
      gid_q     <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      busy_q    <= busy_d;
      fire_q    <= fire_d;
      fire_id_q <= fire_id_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      cnt_q     <= cnt_d;
      snap_q    <= snap_d;
      ptr_q     <= ptr_d;
      gid_q     <= gid_d;
    end
  end

  assign bus.gnt_o     = gnt_q;
  assign bus.busy_o    = busy_q;
  assign bus.fire_o    = fire_q;
  assign bus.fire_id_o = fire_id_q;
  assign bus.done_o    = done_q;
  assign bus.done_id_o = done_id_q;
endmodule
